// File: rtl/median_pkg.sv
// median_pkg: shared pixel width default, window size and feeder FSM states
package median_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int WIN_SIZE = 9;
  typedef enum logic [1:0] {IDLE, SEND, GAP} feeder_state_t;
endpackage

// File: rtl/median_line_buffer.sv
// median_line_buffer: one image line of pixels, combinational read-before-write at one address
// Ports: CLK clock, WE write enable, ADDR column, WD write data, RD read data (old contents at ADDR)
module median_line_buffer
  import median_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 640
) (
  input  logic                     CLK,
  input  logic                     WE,
  input  logic [$clog2(DEPTH)-1:0] ADDR,
  input  logic [WIDTH-1:0]         WD,
  output logic [WIDTH-1:0]         RD
);
  logic [WIDTH-1:0] mem [DEPTH];
  assign RD = mem[ADDR];
  always_ff @(posedge CLK)
    if (WE) mem[ADDR] <= WD;
endmodule

// File: rtl/median_window_feeder.sv
// median_window_feeder: turns a raster pixel stream into 9-pixel 3x3 window bursts for MEDIAN
// Ports: CLK clock, nRST sync active-low reset, PIX_VAL/PIX_SOF/PIX_IN input pixel stream,
//   IN_RDY accept handshake, DSI/DI window burst (9 cycles then one idle cycle),
//   WIN_CNT windows emitted this frame (present only when MEDIAN_WIN_CNT_EN is defined)
module median_window_feeder
  import median_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IMG_WIDTH = 640
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             PIX_VAL,
  input  logic             PIX_SOF,
  input  logic [WIDTH-1:0] PIX_IN,
  output logic             IN_RDY,
  output logic             DSI,
  output logic [WIDTH-1:0] DI
`ifdef MEDIAN_WIN_CNT_EN
  ,
  output logic [15:0]      WIN_CNT
`endif
);
  localparam int CW = $clog2(IMG_WIDTH);
  feeder_state_t state, state_nx;
  logic [3:0] idx;
  logic [CW-1:0] col, ecol;
  logic [1:0] row, erow;
  logic [WIDTH-1:0] win [WIN_SIZE];
  logic [WIDTH-1:0] lb0_rd, lb1_rd;
  logic acc, full, wrap, last;
  // IN_RDY is only high in IDLE, so an accept never collides with a burst
  assign acc  = PIX_VAL & IN_RDY & nRST;
  // a start-of-frame pixel is placed at (0,0) regardless of the running counters
  assign ecol = PIX_SOF ? '0 : col;
  assign erow = PIX_SOF ? '0 : row;
  assign full = erow == 2'd2 && ecol >= CW'(2);
  assign wrap = ecol == CW'(IMG_WIDTH - 1);
  assign last = idx == 4'(WIN_SIZE - 1);
  always_comb
    state_nx = state == IDLE ? (acc && full ? SEND : IDLE) :
               state == SEND ? (last ? GAP : SEND) : IDLE;
  median_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
    .CLK(CLK), .WE(acc), .ADDR(ecol), .WD(PIX_IN), .RD(lb0_rd)
  );
  median_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .CLK(CLK), .WE(acc), .ADDR(ecol), .WD(lb0_rd), .RD(lb1_rd)
  );
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      idx    <= '0;
      col    <= '0;
      row    <= '0;
      IN_RDY <= 1'b0;
      DSI    <= 1'b0;
      DI     <= '0;
    end else begin
      state  <= state_nx;
      IN_RDY <= state_nx == IDLE;
      idx    <= state == SEND ? idx + 4'd1 : '0;
      DSI    <= state == SEND;
      DI     <= state == SEND ? win[idx] : '0;
      if (acc) begin
        col <= wrap ? '0 : ecol + CW'(1);
        row <= (wrap && erow != 2'd2) ? erow + 2'd1 : erow;
      end
    end
  end
  // window held row-major (index r*3+c); contents before row 2 are never emitted
  always_ff @(posedge CLK)
    if (acc) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb1_rd;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb0_rd;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= PIX_IN;
    end
`ifdef MEDIAN_WIN_CNT_EN
  always_ff @(posedge CLK)
    if (!nRST || (acc && PIX_SOF)) WIN_CNT <= '0;
    else if (state == SEND && last) WIN_CNT <= WIN_CNT + 16'd1;
`endif
endmodule

// File: tb/tb_median_window_feeder.sv
// tb_median_window_feeder: scoreboard bench with a frame-array reference model of the window feeder
module tb_median_window_feeder;
  logic CLK = 1'b0, nRST = 1'b0, PIX_VAL = 1'b0, PIX_SOF = 1'b0;
  logic [7:0] PIX_IN = '0, DI;
  logic IN_RDY, DSI;
`ifdef MEDIAN_WIN_CNT_EN
  logic [15:0] WIN_CNT;
`endif
  median_window_feeder #(.WIDTH(8), .IMG_WIDTH(4)) dut (
    .CLK(CLK), .nRST(nRST), .PIX_VAL(PIX_VAL), .PIX_SOF(PIX_SOF), .PIX_IN(PIX_IN),
    .IN_RDY(IN_RDY), .DSI(DSI), .DI(DI)
`ifdef MEDIAN_WIN_CNT_EN
    , .WIN_CNT(WIN_CNT)
`endif
  );
  always #5 CLK = ~CLK;
  int n_cmp = 0, n_err = 0;
  int mrow = 0, mcol = 0, wcnt = 0;
  logic [7:0] img [int];
  logic [71:0] q [$];
  logic [71:0] last_exp = '0;
  logic [71:0] got = '0;
  int cur_n = 0;
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask
  // reference: store every accepted pixel at its true (row,col) and cut windows out of the frame
  task automatic model(input logic [7:0] p, input logic sof, output bit full);
    logic [71:0] w = '0;
    if (sof) begin
      mrow = 0;
      mcol = 0;
      wcnt = 0;
      img.delete();
    end
    img[mrow * 4 + mcol] = p;
    full = mrow >= 2 && mcol >= 2;
    if (full) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w = {w[63:0], img[(mrow - 2 + i) * 4 + mcol - 2 + j]};
      q.push_back(w);
      last_exp = w;
      wcnt++;
    end
    if (mcol == 3) begin
      mcol = 0;
      mrow++;
    end else mcol++;
  endtask
  task automatic do_reset(input int cyc);
    nRST = 1'b0;
    PIX_VAL = 1'b0;
    q.delete();
    img.delete();
    mrow = 0;
    mcol = 0;
    wcnt = 0;
    repeat (cyc) @(posedge CLK);
    #1;
    chk("reset_outputs", {IN_RDY, DSI, DI}, '0);
`ifdef MEDIAN_WIN_CNT_EN
    chk("reset_win_cnt", WIN_CNT, 0);
`endif
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rdy_after_release", IN_RDY, 1);
  endtask
  task automatic send(input logic [7:0] p, input logic sof, input bit abort = 1'b0);
    bit full;
    int n = 0, first = -1;
    PIX_VAL = 1'b1;
    PIX_IN = p;
    PIX_SOF = sof;
    model(p, sof, full);
    @(posedge CLK);
    #1;
    // junk offered while not ready must be ignored
    PIX_IN = 8'($urandom);
    PIX_SOF = 1'($urandom);
    if (abort) begin
      repeat (5) begin
        @(posedge CLK);
        #1;
      end
      PIX_VAL = 1'b0;
      chk("abort_idx4", {DSI, DI}, {1'b1, last_exp[39:32]});
      do_reset(1);
      return;
    end
    while (!IN_RDY && n < 40) begin
      if (DSI && first < 0) first = n;
      @(posedge CLK);
      #1;
      n++;
    end
    PIX_VAL = 1'b0;
    chk("handshake_timing", {32'(n), 32'(first)}, full ? {32'd10, 32'd1} : {32'd0, 32'hFFFF_FFFF});
`ifdef MEDIAN_WIN_CNT_EN
    chk("win_cnt", WIN_CNT, wcnt);
`endif
  endtask
  always @(negedge CLK) begin
    if (!nRST) cur_n = 0;
    else if (DSI) begin
      got = {got[63:0], DI};
      cur_n++;
      if (cur_n == 9) begin
        cur_n = 0;
        if (q.size() == 0) chk("unexpected_burst", got, 'x);
        else chk("window", got, q.pop_front());
      end
    end else begin
      chk("idle_di_and_burst_len", {DI, 32'(cur_n)}, '0);
      cur_n = 0;
    end
  end
  initial begin
    do_reset(3);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!(r == 3 && c == 3)) send(8'(r * 4 + c), r == 0 && c == 0);
    send(8'd0, 1'b1);
    for (int i = 1; i < 8; i++) send(8'(i), 1'b0);
    send(8'd8, 1'b0);
    send(8'd9, 1'b0);
    send(8'd10, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) send(8'(i), i == 0);
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge CLK);
            #1;
          end
          send(8'($urandom), (r == 0 && c == 0) || $urandom_range(0, 19) == 0);
        end
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_drained", 72'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
